// File: rtl/pw_conv_group_serializer_pkg.sv
// Shared definitions for the pointwise-conv channel-group serializer and the PW MAC array.
// Default element width and group size live here so both sides agree on the beat format.
package pw_conv_pkg;

  localparam int PW_DATA_WIDTH = 8;
  localparam int PW_GROUP_CH   = 9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // A single group still needs a one-bit index port.
  function automatic int pw_idx_w(input int num_groups);
    return (num_groups > 1) ? $clog2(num_groups) : 1;
  endfunction

endpackage

// File: rtl/pw_conv_group_serializer_group_mux.sv
// pw_group_mux: combinational group-slice selector over a captured feature vector.
// With PW_SER_ZERO_SKIP_EN defined it also reports which groups carry nonzero data.
module pw_group_mux
  import pw_conv_pkg::*;
#(
  parameter  int DATA_WIDTH = PW_DATA_WIDTH,
  parameter  int GROUP_CH   = PW_GROUP_CH,
  parameter  int NUM_GROUPS = 2,
  parameter  int IDX_W      = pw_idx_w(NUM_GROUPS),
  localparam int GROUP_W    = DATA_WIDTH * GROUP_CH,
  localparam int SRC_W      = GROUP_W * NUM_GROUPS
) (
  input  logic [SRC_W-1:0]      i_src,
  input  logic [IDX_W-1:0]      i_sel,
  output logic [GROUP_W-1:0]    o_group
`ifdef PW_SER_ZERO_SKIP_EN
  ,
  output logic [NUM_GROUPS-1:0] o_nonzero
`endif
);

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    o_group = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (i_sel == IDX_W'(g)) o_group = i_src[g*GROUP_W +: GROUP_W];
    end
  end

`ifdef PW_SER_ZERO_SKIP_EN
  // The last group is forced present so a priority pick always terminates on it.
  always_comb begin
    o_nonzero = '0;
    for (int g = 0; g < NUM_GROUPS - 1; g++) begin
      o_nonzero[g] = |i_src[g*GROUP_W +: GROUP_W];
    end
    o_nonzero[NUM_GROUPS-1] = 1'b1;
  end
`endif

endmodule

// File: rtl/pw_conv_group_serializer.sv
// Serializes one NUM_GROUPS*GROUP_CH-channel vector into NUM_GROUPS beats of GROUP_CH channels.
// Optional feature macro: PW_SER_ZERO_SKIP_EN (skip all-zero non-final groups).
module pw_conv_group_serializer
  import pw_conv_pkg::*;
#(
  parameter int DATA_WIDTH = PW_DATA_WIDTH,
  parameter int GROUP_CH   = PW_GROUP_CH,
  parameter int NUM_GROUPS = 2,
  parameter int IN_WIDTH   = DATA_WIDTH * GROUP_CH * NUM_GROUPS,
  parameter int OUT_WIDTH  = DATA_WIDTH * GROUP_CH,
  parameter int IDX_W      = pw_idx_w(NUM_GROUPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_first,
  output logic                 out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

  ser_state_e             r_state;
  ser_state_e             w_state_nxt;
  logic [IN_WIDTH-1:0]    r_cap;
  logic [OUT_WIDTH-1:0]   r_data;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_first;
  logic                   r_last;

  logic                   w_fire;
  logic                   w_accept;
  logic                   w_advance;
  logic [IN_WIDTH-1:0]    w_src;
  logic [IDX_W-1:0]       w_first_idx;
  logic [IDX_W-1:0]       w_next_idx;
  logic [IDX_W-1:0]       w_sel;
  logic                   w_sel_last;
  logic [OUT_WIDTH-1:0]   w_group;

  assign out_valid = (r_state == SEND);
  assign w_fire    = out_valid & out_ready;
  // Combinational from out_ready: a new vector slips in on the cycle the final beat leaves.
  assign in_ready  = (r_state == IDLE) | (w_fire & r_last);
  assign w_accept  = in_valid & in_ready;
  assign w_advance = w_fire & ~r_last;

  // On accept the first group comes straight from in_data; otherwise from the capture register.
  assign w_src      = w_accept ? in_data : r_cap;
  assign w_sel      = w_accept ? w_first_idx : w_next_idx;
  assign w_sel_last = (w_sel == LAST_IDX);

`ifdef PW_SER_ZERO_SKIP_EN
  logic [NUM_GROUPS-1:0] w_nonzero;
  logic [NUM_GROUPS-1:0] r_mask;

  pw_group_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .GROUP_CH   (GROUP_CH),
    .NUM_GROUPS (NUM_GROUPS),
    .IDX_W      (IDX_W)
  ) u_mux (
    .i_src     (w_src),
    .i_sel     (w_sel),
    .o_group   (w_group),
    .o_nonzero (w_nonzero)
  );

  // Descending scans so the lowest qualifying group wins.
  always_comb begin
    w_first_idx = LAST_IDX;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (w_nonzero[g]) w_first_idx = IDX_W'(g);
    end
  end

  always_comb begin
    w_next_idx = LAST_IDX;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (r_mask[g] && (g > int'(r_idx))) w_next_idx = IDX_W'(g);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_mask <= '0;
    else if (w_accept) r_mask <= w_nonzero;
  end
`else
  pw_group_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .GROUP_CH   (GROUP_CH),
    .NUM_GROUPS (NUM_GROUPS),
    .IDX_W      (IDX_W)
  ) u_mux (
    .i_src   (w_src),
    .i_sel   (w_sel),
    .o_group (w_group)
  );

  assign w_first_idx = '0;
  assign w_next_idx  = r_idx + IDX_W'(1);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_fire && r_last && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the capture register is plain flops, not a RAM, so it takes the async reset
  // along with the output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cap   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_cap   <= in_data;
      r_data  <= w_group;
      r_idx   <= w_sel;
      r_first <= 1'b1;
      r_last  <= w_sel_last;
    end else if (w_advance) begin
      r_data  <= w_group;
      r_idx   <= w_sel;
      r_first <= 1'b0;
      r_last  <= w_sel_last;
    end
  end

  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_first = r_first;
  assign out_last  = r_last;

endmodule

// File: tb/tb_pw_conv_group_serializer.sv
// Self-checking bench: default serializer (2x9) and a 4x4 variant against a queue-based beat model.
// Honours PW_SER_ZERO_SKIP_EN in the model when the bundle is built with it.
module tb_pw_conv_group_serializer;

  typedef struct {
    logic [71:0] data;
    logic [5:0]  idx;
    bit          first;
    bit          last;
  } beat_t;

  logic         clk;
  logic         rstn;

  logic         iv_a, ir_a, ov_a, ord_a, f_a, l_a;
  logic [143:0] id_a;
  logic [71:0]  od_a;
  logic [0:0]   idx_a;

  logic         iv_b, ir_b, ov_b, ord_b, f_b, l_b;
  logic [127:0] id_b;
  logic [31:0]  od_b;
  logic [1:0]   idx_b;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[2][$];
  beat_t scratch[$];

  pw_conv_group_serializer dut_a (
    .clk (clk), .rstn (rstn),
    .in_valid (iv_a), .in_ready (ir_a), .in_data (id_a),
    .out_valid (ov_a), .out_ready (ord_a), .out_data (od_a),
    .out_idx (idx_a), .out_first (f_a), .out_last (l_a)
  );

  pw_conv_group_serializer #(.NUM_GROUPS(4), .GROUP_CH(4)) dut_b (
    .clk (clk), .rstn (rstn),
    .in_valid (iv_b), .in_ready (ir_b), .in_data (id_b),
    .out_valid (ov_b), .out_ready (ord_b), .out_data (od_b),
    .out_idx (idx_b), .out_first (f_b), .out_last (l_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: group g is channels g*gc..g*gc+gc-1; optionally drop zero non-final groups.
  task automatic build(input int u, input logic [143:0] v);
    int           ng, gc;
    logic [143:0] grp, msk;
    bit           first;
    beat_t        b;
    ng = (u == 0) ? 2 : 4;
    gc = (u == 0) ? 9 : 4;
    scratch.delete();
    first = 1'b1;
    msk = (144'd1 << (gc * 8)) - 144'd1;
    for (int g = 0; g < ng; g++) begin
      grp = (v >> (g * gc * 8)) & msk;
`ifdef PW_SER_ZERO_SKIP_EN
      if (g < ng - 1 && grp == '0) continue;
`endif
      b.data  = grp[71:0];
      b.idx   = 6'(g);
      b.first = first;
      b.last  = (g == ng - 1);
      first   = 1'b0;
      scratch.push_back(b);
    end
  endtask

  task automatic mon(input int u, input logic ov, input logic [71:0] od, input logic [5:0] idx,
                     input logic f, input logic l, input logic ir, input logic iv,
                     input logic [143:0] id, input logic ordy);
    bit    exp_ir;
    beat_t h;
    string p;
    p = (u == 0) ? "a" : "b";
    exp_ir = (exp_q[u].size() == 0) || (ordy && exp_q[u][0].last);
    check({p, " in_ready"}, ir, exp_ir);
    check({p, " out_valid"}, ov, exp_q[u].size() != 0);
    if (ov && exp_q[u].size() != 0) begin
      h = exp_q[u][0];
      check({p, " out_data"}, od, h.data);
      check({p, " out_idx"}, idx, h.idx);
      check({p, " out_first"}, f, h.first);
      check({p, " out_last"}, l, h.last);
      if (ordy) void'(exp_q[u].pop_front());
    end
    if (iv && exp_ir) begin
      build(u, id);
      foreach (scratch[i]) exp_q[u].push_back(scratch[i]);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst out_valid", {ov_a, ov_b}, 2'b00);
      check("rst out_data", {od_a, od_b}, '0);
      check("rst out_idx", {idx_a, idx_b}, '0);
      check("rst first/last", {f_a, l_a, f_b, l_b}, 4'b0000);
      check("rst in_ready", {ir_a, ir_b}, 2'b11);
      exp_q[0].delete();
      exp_q[1].delete();
    end else begin
      mon(0, ov_a, od_a, {5'b0, idx_a}, f_a, l_a, ir_a, iv_a, id_a, ord_a);
      mon(1, ov_b, {40'b0, od_b}, {4'b0, idx_b}, f_b, l_b, ir_b, iv_b, {16'b0, id_b}, ord_b);
    end
  end

  task automatic drive(input int u, input bit v, input logic [143:0] d, input bit r);
    if (u == 0) begin
      iv_a = v; id_a = d; ord_a = r;
    end else begin
      iv_b = v; id_b = d[127:0]; ord_b = r;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] rand_vec(input int u);
    int           ng, gc;
    logic [143:0] v;
    v  = '0;
    ng = (u == 0) ? 2 : 4;
    gc = (u == 0) ? 9 : 4;
    for (int g = 0; g < ng; g++) begin
      if ($urandom_range(3) != 0) begin
        for (int c = 0; c < gc; c++) v[(g*gc+c)*8 +: 8] = 8'($urandom);
      end
    end
    return v;
  endfunction

  task automatic random_run(input int u, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive(u, $urandom_range(3) != 0, rand_vec(u), $urandom_range(3) != 0);
      step();
    end
    drive(u, 1'b0, '0, 1'b1);
    repeat (12) step();
    check(u == 0 ? "a drained" : "b drained", exp_q[u].size(), 0);
  endtask

  logic [143:0] vec_c1, vec_b4, va, vb, vc;
  localparam logic [71:0] LIT_A0 = 72'h090807060504030201;
  localparam logic [71:0] LIT_A1 = 72'h1211100f0e0d0c0b0a;
  int beats, pulses;

  initial begin
    rstn = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    vec_c1 = '0;
    vec_b4 = '0;
    for (int c = 0; c < 18; c++) vec_c1[c*8 +: 8] = 8'(c + 1);
    for (int c = 0; c < 16; c++) vec_b4[c*8 +: 8] = 8'(c + 1);

    // Pin the model itself with hand-computed beats.
    build(0, vec_c1);
    check("model a beats", scratch.size(), 2);
    check("model a g0", scratch[0].data, LIT_A0);
    check("model a g1", scratch[1].data, LIT_A1);
    check("model a g1 last", scratch[1].last, 1'b1);
    build(1, vec_b4);
    check("model b beats", scratch.size(), 4);
    check("model b g3", scratch[3].data, 72'h100f0e0d);
    check("model b g3 idx", scratch[3].idx, 6'd3);

    repeat (3) step();
    rstn = 1'b1;
    drive(0, 1'b0, '0, 1'b1);
    drive(1, 1'b0, '0, 1'b1);
    repeat (10) step();

    // Single vector, channels 1..18.
    drive(0, 1'b1, vec_c1, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("a beat1 data", od_a, LIT_A0);
    check("a beat1 idx/first", {ov_a, idx_a, f_a, l_a}, 4'b1010);
    @(negedge clk);
    check("a beat2 data", od_a, LIT_A1);
    check("a beat2 idx/last", {ov_a, idx_a, f_a, l_a}, 4'b1101);
    repeat (3) step();

    // Back-to-back A, B, C with in_valid held high.
    va = rand_vec(0) | 144'h1;
    vb = rand_vec(0) | 144'h1;
    vc = rand_vec(0) | 144'h1;
    beats = 0;
    pulses = 0;
    drive(0, 1'b1, va, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1)      drive(0, 1'b1, vb, 1'b1);
      else if (k == 3) drive(0, 1'b1, vc, 1'b1);
      else if (k == 5) drive(0, 1'b0, '0, 1'b1);
      @(negedge clk);
      if (ov_a) beats++;
      if (ir_a) pulses++;
    end
    check("b2b beats", beats, 6);
    check("b2b in_ready pulses", pulses, 3);
    repeat (3) step();

    // Backpressure on beat idx0.
    drive(0, 1'b1, vec_c1, 1'b0);
    step();
    drive(0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall data", od_a, LIT_A0);
      check("stall idx/ready", {ov_a, idx_a, ir_a}, 3'b100);
      step();
    end
    drive(0, 1'b0, '0, 1'b1);
    repeat (4) step();

`ifdef PW_SER_ZERO_SKIP_EN
    drive(0, 1'b1, vec_c1 & ~((144'd1 << 72) - 144'd1), 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("skip data", od_a, LIT_A1);
    check("skip idx/first/last", {ov_a, idx_a, f_a, l_a}, 4'b1111);
    @(negedge clk);
    check("skip single beat", ov_a, 1'b0);
    step();
    drive(0, 1'b1, '0, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("zero vec data", od_a, 72'h0);
    check("zero vec idx/first/last", {ov_a, idx_a, f_a, l_a}, 4'b1111);
    repeat (3) step();
`endif

    random_run(0, 1500);

    // 4x4 variant: full vector, then reset after idx1.
    drive(1, 1'b1, vec_b4, 1'b1);
    step();
    drive(1, 1'b0, '0, 1'b1);
    @(negedge clk);
    check("b beat0 data", od_b, 32'h04030201);
    check("b beat0 flags", {ov_b, idx_b, f_b, l_b}, 5'b10010);
    repeat (5) step();
    drive(1, 1'b1, vec_b4, 1'b1);
    step();
    drive(1, 1'b0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("b pre-reset idx", idx_b, 2'd1);
    #2 rstn = 1'b0;
    @(negedge clk);
    check("b reset drops beat", ov_b, 1'b0);
    step();
    rstn = 1'b1;
    repeat (10) step();

    random_run(1, 1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
